// File: rtl/settings_fetcher.sv
// Settings fetcher: on each FLAG rising edge, reads a channel's settings block from BRAM into a
// shadow buffer and commits it atomically with a one-cycle UPDATE pulse. Checksum: SETTINGS_FETCHER_CHECKSUM_EN.
module settings_fetcher #(
    parameter int unsigned NUM_CH     = 6,
    parameter int unsigned MAX_WORDS  = 32,
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic                                   CLK,
    input  logic                                   RST,
    input  logic [NUM_CH-1:0]                      FLAG,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]           CH_BASE,
    input  logic [NUM_CH*6-1:0]                    CH_LEN,
    output logic                                   BRAM_EN,
    output logic [ADDR_WIDTH-1:0]                  BRAM_ADDR,
    input  logic [DATA_WIDTH-1:0]                  BRAM_DOUT,
    output logic [NUM_CH*MAX_WORDS*DATA_WIDTH-1:0] SETTINGS,
    output logic [NUM_CH-1:0]                      UPDATE,
    output logic                                   BUSY,
    output logic [NUM_CH-1:0]                      ERR
);
    localparam int unsigned LEN_W = 6;
    localparam int unsigned CNT_W = $clog2(MAX_WORDS + 1);
    localparam int unsigned IDX_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned WORDS = NUM_CH * MAX_WORDS;

    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DRAIN, ST_COMMIT} state_e;

    state_e                                  state_q, state_d;
    logic [CH_W-1:0]                         ch_q, ch_d;
    logic [CNT_W-1:0]                        len_q, len_d;
    logic [CNT_W-1:0]                        iss_q, iss_d;
    logic [CNT_W-1:0]                        cap_q, cap_d;
    logic [NUM_CH-1:0]                       pend_q, pend_d;
    logic [NUM_CH-1:0]                       hist_q, hist_d;
    logic                                    en_q, en_d;
    logic [ADDR_WIDTH-1:0]                   addr_q, addr_d;
    logic [RD_LATENCY-1:0]                   pipe_q, pipe_d;
    logic [MAX_WORDS-1:0][DATA_WIDTH-1:0]    shadow_q, shadow_d;
    logic [WORDS-1:0][DATA_WIDTH-1:0]        settings_q, settings_d;
    logic [NUM_CH-1:0]                       upd_q, upd_d;
    logic                                    busy_q, busy_d;
    logic [NUM_CH-1:0]                       clr;
    int                                      sel;
    logic [LEN_W-1:0]                        sel_raw;
    logic [CNT_W-1:0]                        sel_len;
    logic [CNT_W-1:0]                        ncommit;
`ifdef SETTINGS_FETCHER_CHECKSUM_EN
    logic [NUM_CH-1:0]                       err_q, err_d;
    logic [DATA_WIDTH-1:0]                   chk;
    logic                                    commit_ok;
`endif

    // Next-state, read sequencing, capture pipeline and commit.
    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        len_d      = len_q;
        iss_d      = iss_q;
        cap_d      = cap_q;
        en_d       = en_q;
        addr_d     = addr_q;
        shadow_d   = shadow_q;
        settings_d = settings_q;
        upd_d      = '0;
        hist_d     = FLAG;
        clr        = '0;
        sel        = 0;
        sel_raw    = '0;
        sel_len    = '0;
        ncommit    = '0;
        pipe_d     = (pipe_q << 1) | RD_LATENCY'(en_q);
`ifdef SETTINGS_FETCHER_CHECKSUM_EN
        err_d      = '0;
        chk        = '0;
        commit_ok  = 1'b0;
`endif
        // A read issued in cycle c is captured at the edge RD_LATENCY cycles later.
        if (pipe_q[RD_LATENCY-1]) begin
            shadow_d[IDX_W'(cap_q)] = BRAM_DOUT;
            cap_d = cap_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (|pend_q) begin
                    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
                        if (pend_q[i]) sel = i;
                    end
                    sel_raw = CH_LEN[sel*LEN_W +: LEN_W];
                    sel_len = (32'(sel_raw) > MAX_WORDS) ? CNT_W'(MAX_WORDS) : CNT_W'(sel_raw);
                    ch_d    = CH_W'(sel);
                    len_d   = sel_len;
                    clr[sel] = 1'b1;
                    cap_d   = '0;
                    if (sel_len == '0) begin
                        state_d = ST_COMMIT;
                    end else begin
                        state_d = ST_READ;
                        en_d    = 1'b1;
                        addr_d  = CH_BASE[sel*ADDR_WIDTH +: ADDR_WIDTH];
                        iss_d   = CNT_W'(1);
                    end
                end
            end
            ST_READ: begin
                if (iss_q == len_q) begin
                    en_d    = 1'b0;
                    state_d = ST_DRAIN;
                end else begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    iss_d  = iss_q + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (pipe_q[RD_LATENCY-1] && (cap_q == len_q - CNT_W'(1))) state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
`ifdef SETTINGS_FETCHER_CHECKSUM_EN
                // Last word is the XOR of the others; a block shorter than two words never matches.
                for (int w = 0; w < int'(MAX_WORDS); w++) begin
                    if (w + 1 < int'(len_q)) chk = chk ^ shadow_q[w];
                end
                commit_ok    = (len_q >= CNT_W'(2)) && (chk == shadow_q[IDX_W'(len_q - CNT_W'(1))]);
                ncommit      = commit_ok ? len_q - CNT_W'(1) : '0;
                upd_d[ch_q]  = commit_ok;
                err_d[ch_q]  = !commit_ok;
`else
                ncommit      = len_q;
                upd_d[ch_q]  = 1'b1;
`endif
                for (int w = 0; w < int'(MAX_WORDS); w++) begin
                    if (w < int'(ncommit)) settings_d[int'(ch_q)*int'(MAX_WORDS) + w] = shadow_q[w];
                end
            end
            default: state_d = ST_IDLE;
        endcase

        pend_d = (pend_q & ~clr) | (FLAG & ~hist_q);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            ch_q       <= '0;
            len_q      <= '0;
            iss_q      <= '0;
            cap_q      <= '0;
            pend_q     <= '0;
            hist_q     <= '0;
            en_q       <= 1'b0;
            addr_q     <= '0;
            pipe_q     <= '0;
            shadow_q   <= '0;
            settings_q <= '0;
            upd_q      <= '0;
            busy_q     <= 1'b0;
`ifdef SETTINGS_FETCHER_CHECKSUM_EN
            err_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            len_q      <= len_d;
            iss_q      <= iss_d;
            cap_q      <= cap_d;
            pend_q     <= pend_d;
            hist_q     <= hist_d;
            en_q       <= en_d;
            addr_q     <= addr_d;
            pipe_q     <= pipe_d;
            shadow_q   <= shadow_d;
            settings_q <= settings_d;
            upd_q      <= upd_d;
            busy_q     <= busy_d;
`ifdef SETTINGS_FETCHER_CHECKSUM_EN
            err_q      <= err_d;
`endif
        end
    end

    assign BRAM_EN   = en_q;
    assign BRAM_ADDR = addr_q;
    assign SETTINGS  = settings_q;
    assign UPDATE    = upd_q;
    assign BUSY      = busy_q;
`ifdef SETTINGS_FETCHER_CHECKSUM_EN
    assign ERR       = err_q;
`else
    assign ERR       = '0;
`endif

endmodule

// File: tb/tb_settings_fetcher.sv
// Testbench for settings_fetcher: directed boundary cases plus randomized flag bursts,
// checked against a word-level reference model of committed settings and completion order.
module tb_settings_fetcher;
    localparam int unsigned NUM_CH = 6;
    localparam int unsigned MAXW   = 32;
    localparam int unsigned AW     = 14;
    localparam int unsigned DW     = 16;
    localparam int unsigned RDL    = 2;

    logic                         CLK = 1'b0;
    logic                         RST;
    logic [NUM_CH-1:0]            FLAG;
    logic [NUM_CH*AW-1:0]         CH_BASE;
    logic [NUM_CH*6-1:0]          CH_LEN;
    logic                         BRAM_EN;
    logic [AW-1:0]                BRAM_ADDR;
    logic [DW-1:0]                BRAM_DOUT;
    logic [NUM_CH*MAXW*DW-1:0]    SETTINGS;
    logic [NUM_CH-1:0]            UPDATE;
    logic                         BUSY;
    logic [NUM_CH-1:0]            ERR;

    settings_fetcher #(.NUM_CH(NUM_CH), .MAX_WORDS(MAXW), .ADDR_WIDTH(AW),
                       .DATA_WIDTH(DW), .RD_LATENCY(RDL)) dut (
        .CLK(CLK), .RST(RST), .FLAG(FLAG), .CH_BASE(CH_BASE), .CH_LEN(CH_LEN),
        .BRAM_EN(BRAM_EN), .BRAM_ADDR(BRAM_ADDR), .BRAM_DOUT(BRAM_DOUT),
        .SETTINGS(SETTINGS), .UPDATE(UPDATE), .BUSY(BUSY), .ERR(ERR));

    always #5 CLK = ~CLK;

    // BRAM with RDL-cycle read latency
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rd_pipe [RDL];
    always @(posedge CLK) begin
        rd_pipe[0] <= BRAM_EN ? mem[BRAM_ADDR] : 16'hDEAD;
        for (int j = 1; j < int'(RDL); j++) rd_pipe[j] <= rd_pipe[j-1];
    end
    assign BRAM_DOUT = rd_pipe[RDL-1];

    int          cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_pass   = 0;
    int unsigned base_a [NUM_CH];
    int unsigned len_a  [NUM_CH];
    logic [DW-1:0] exp_set [NUM_CH][MAXW];
    int          done_ch[$];
    int          done_cyc[$];
    int          addr_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic int eff_len(input int ch);
        return (len_a[ch] > MAXW) ? int'(MAXW) : int'(len_a[ch]);
    endfunction

    function automatic logic [DW-1:0] rd(input int ch, input int w);
        return mem[(base_a[ch] + w) % (1 << AW)];
    endfunction

    function automatic logic [DW-1:0] got_word(input int ch, input int w);
        return SETTINGS[(ch*MAXW + w)*DW +: DW];
    endfunction

    // Reference: a completed fetch commits memory words base..base+L-1 (checksum rules if enabled)
    task automatic model_complete(input int ch);
        int L;
        int n;
        logic ok;
        logic [DW-1:0] x;
        L = eff_len(ch);
`ifdef SETTINGS_FETCHER_CHECKSUM_EN
        x = '0;
        for (int w = 0; w < L - 1; w++) x = x ^ rd(ch, w);
        ok = (L >= 2) && (x == rd(ch, L - 1));
        n  = L - 1;
`else
        x  = '0;
        ok = 1'b1;
        n  = L;
`endif
        check($sformatf("kind_ch%0d", ch), {30'd0, UPDATE[ch], ERR[ch]}, ok ? 32'd2 : 32'd1);
        if (ok) for (int w = 0; w < n; w++) exp_set[ch][w] = rd(ch, w);
        for (int w = 0; w < int'(MAXW); w++)
            check($sformatf("set_ch%0d_w%0d", ch, w), 32'(got_word(ch, w)), 32'(exp_set[ch][w]));
    endtask

    always @(negedge CLK) begin
        if (RST) begin
            for (int c = 0; c < int'(NUM_CH); c++)
                for (int w = 0; w < int'(MAXW); w++) exp_set[c][w] = '0;
        end else begin
            if (BRAM_EN) addr_q.push_back(int'(BRAM_ADDR));
            if (|(UPDATE | ERR)) begin
                check("onehot", 32'($countones(UPDATE | ERR)), 32'd1);
                for (int c = 0; c < int'(NUM_CH); c++) begin
                    if (UPDATE[c] | ERR[c]) begin
                        done_ch.push_back(c);
                        done_cyc.push_back(cyc);
                        model_complete(c);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    task automatic apply_cfg();
        for (int c = 0; c < int'(NUM_CH); c++) begin
            CH_BASE[c*AW +: AW] = AW'(base_a[c]);
            CH_LEN[c*6 +: 6]    = 6'(len_a[c]);
        end
    endtask

    task automatic wait_idle();
        int quiet;
        quiet = 0;
        tick(3);
        for (int i = 0; i < 3000 && quiet < 4; i++) begin
            @(negedge CLK);
            quiet = BUSY ? 0 : quiet + 1;
        end
        tick(1);
        check("idle_reached", 32'(quiet >= 4), 32'd1);
    endtask

    task automatic check_all(input string tag);
        for (int c = 0; c < int'(NUM_CH); c++)
            for (int w = 0; w < int'(MAXW); w++)
                check($sformatf("%s_ch%0d_w%0d", tag, c, w), 32'(got_word(c, w)), 32'(exp_set[c][w]));
    endtask

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic int exp_lat(input int L);
        return (L == 0) ? 2 : 2 + L + int'(RDL);
    endfunction

    // Pulse FLAG bits for n cycles; returns the cycle index of the first sampling edge
    task automatic pulse(input logic [NUM_CH-1:0] f, input int n, output int ts);
        FLAG = f;
        ts = cyc + 1;
        tick(n);
        FLAG = '0;
    endtask

    initial begin
        int ts, a0, d0, cnt1, cnt3, L0;
        logic [NUM_CH-1:0] sub;
        int exp_order[$];

        RST = 1'b1; FLAG = '0; CH_BASE = '0; CH_LEN = '0;
        for (int c = 0; c < int'(NUM_CH); c++) begin base_a[c] = 0; len_a[c] = 0; end
        for (int i = 0; i < (1 << AW); i++) mem[i] = 16'($urandom);
        tick(3);
        RST = 1'b0;
        @(negedge CLK);
        check("rst_busy", 32'(BUSY), 0);
        check("rst_en", 32'(BRAM_EN), 0);
        check("rst_addr", 32'(BRAM_ADDR), 0);
        check("rst_upd", 32'(UPDATE), 0);
        check("rst_err", 32'(ERR), 0);
        check_all("rst");
        tick(1);

        // Single fetch, ch2
        base_a[2] = 32'h100; len_a[2] = 5; apply_cfg();
        for (int i = 0; i < 5; i++) mem[32'h100 + i] = 16'(32'hA0 + i);
        a0 = addr_q.size(); d0 = done_ch.size();
        pulse(6'b000100, 1, ts);
        wait_idle();
        check("t1_ndone", 32'(done_ch.size() - d0), 1);
        check("t1_ch", 32'(qat(done_ch, d0)), 2);
        check("t1_lat", 32'(qat(done_cyc, d0) - ts), 32'(exp_lat(5)));
        check("t1_nrd", 32'(addr_q.size() - a0), 5);
        for (int i = 0; i < 5; i++) check("t1_addr", 32'(qat(addr_q, a0 + i)), 32'h100 + i);
        check_all("t1");

        // Simultaneous edges ch0, ch3, ch5 served in ascending order, back-to-back
        base_a[0] = 32'h200; base_a[3] = 32'h300; base_a[5] = 32'h500;
        len_a[0] = 3; len_a[3] = 3; len_a[5] = 3; apply_cfg();
        d0 = done_ch.size();
        pulse(6'b101001, 1, ts);
        wait_idle();
        check("t2_ndone", 32'(done_ch.size() - d0), 3);
        check("t2_o0", 32'(qat(done_ch, d0)), 0);
        check("t2_o1", 32'(qat(done_ch, d0 + 1)), 3);
        check("t2_o2", 32'(qat(done_ch, d0 + 2)), 5);
        for (int k = 0; k < 3; k++)
            check("t2_lat", 32'(qat(done_cyc, d0 + k) - ts), 32'((k + 1) * exp_lat(3)));

        // Zero length: commit slot 2 cycles after flag, no reads
        base_a[4] = 32'h800; len_a[4] = 0; apply_cfg();
        a0 = addr_q.size(); d0 = done_ch.size();
        pulse(6'b010000, 1, ts);
        wait_idle();
        check("t3_lat", 32'(qat(done_cyc, d0) - ts), 2);
        check("t3_nrd", 32'(addr_q.size() - a0), 0);

        // Length 40 clamps to 32 reads
        base_a[0] = 32'h1000; len_a[0] = 40; apply_cfg();
        a0 = addr_q.size(); d0 = done_ch.size();
        pulse(6'b000001, 1, ts);
        wait_idle();
        check("t4_nrd", 32'(addr_q.size() - a0), 32);
        check("t4_addr_last", 32'(qat(addr_q, a0 + 31)), 32'h101F);
        check("t4_lat", 32'(qat(done_cyc, d0) - ts), 32'(exp_lat(32)));

        // Address wrap
        base_a[1] = 32'h3FFE; len_a[1] = 4; apply_cfg();
        a0 = addr_q.size();
        pulse(6'b000010, 1, ts);
        wait_idle();
        check("t5_nrd", 32'(addr_q.size() - a0), 4);
        check("t5_a0", 32'(qat(addr_q, a0)), 32'h3FFE);
        check("t5_a1", 32'(qat(addr_q, a0 + 1)), 32'h3FFF);
        check("t5_a2", 32'(qat(addr_q, a0 + 2)), 32'h0000);
        check("t5_a3", 32'(qat(addr_q, a0 + 3)), 32'h0001);
        check_all("t5");

        // Re-trigger during READ coalesces into one refetch with fresh data
        base_a[1] = 32'h40; len_a[1] = 8; apply_cfg();
        d0 = done_ch.size();
        pulse(6'b000010, 3, ts);
        FLAG = 6'b000010; tick(1); FLAG = '0; tick(1);
        FLAG = 6'b000010; tick(1); FLAG = '0;
        cnt1 = 0;
        for (int i = 0; i < 200 && cnt1 == 0; i++) begin
            @(negedge CLK); #1;
            if (UPDATE[1] | ERR[1]) begin
                cnt1 = 1;
                for (int w = 0; w < 8; w++) mem[32'h40 + w] = mem[32'h40 + w] ^ 16'h5A5A;
            end
        end
        check("t6_first", 32'(cnt1), 1);
        wait_idle();
        cnt1 = 0;
        for (int i = d0; i < done_ch.size(); i++) if (done_ch[i] == 1) cnt1++;
        check("t6_count", 32'(cnt1), 2);

        // Reset mid-fetch aborts; flag held through reset fetches once afterwards
        base_a[3] = 32'h600; len_a[3] = 8; base_a[1] = 32'h900; len_a[1] = 6; apply_cfg();
        pulse(6'b001000, 1, ts);
        FLAG = 6'b000010;
        tick(3);
        d0 = done_ch.size();
        RST = 1'b1; tick(1); RST = 1'b0;
        @(negedge CLK);
        check("t7_busy", 32'(BUSY), 0);
        check("t7_en", 32'(BRAM_EN), 0);
        check("t7_addr", 32'(BRAM_ADDR), 0);
        check("t7_upd", 32'(UPDATE), 0);
        check_all("t7_rst");
        wait_idle();
        tick(20);
        FLAG = '0;
        cnt1 = 0; cnt3 = 0;
        for (int i = d0; i < done_ch.size(); i++) begin
            if (done_ch[i] == 1) cnt1++;
            if (done_ch[i] == 3) cnt3++;
        end
        check("t7_ch1_once", 32'(cnt1), 1);
        check("t7_ch3_none", 32'(cnt3), 0);
        check_all("t7");

`ifdef SETTINGS_FETCHER_CHECKSUM_EN
        base_a[2] = 32'h700; len_a[2] = 3; apply_cfg();
        mem[32'h700] = 16'h1234; mem[32'h701] = 16'h00FF; mem[32'h702] = 16'h12CB;
        d0 = done_ch.size();
        pulse(6'b000100, 1, ts);
        wait_idle();
        check("cs_ok_w0", 32'(got_word(2, 0)), 32'h1234);
        check("cs_ok_w1", 32'(got_word(2, 1)), 32'h00FF);
        check("cs_ok_w2", 32'(got_word(2, 2)), 32'h0000);
        mem[32'h702] = 16'h12CA; mem[32'h700] = 16'h4321;
        pulse(6'b000100, 1, ts);
        wait_idle();
        check("cs_bad_w0", 32'(got_word(2, 0)), 32'h1234);
        check("cs_ndone", 32'(done_ch.size() - d0), 2);
`endif

        // Randomized bursts: every flagged channel completes once, ascending, lowest at idle latency
        for (int it = 0; it < 25; it++) begin
            sub = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
            exp_order.delete();
            L0 = -1;
            for (int c = 0; c < int'(NUM_CH); c++) begin
                if (sub[c]) begin
                    base_a[c] = $urandom_range(0, (1 << AW) - 1);
                    len_a[c]  = $urandom_range(0, 40);
                    for (int w = 0; w < eff_len(c); w++) mem[(base_a[c] + w) % (1 << AW)] = 16'($urandom);
                    if ($urandom_range(0, 1) == 1 && eff_len(c) >= 2) begin
                        logic [DW-1:0] x;
                        x = '0;
                        for (int w = 0; w < eff_len(c) - 1; w++) x = x ^ rd(c, w);
                        mem[(base_a[c] + eff_len(c) - 1) % (1 << AW)] = x;
                    end
                    exp_order.push_back(c);
                    if (L0 < 0) L0 = eff_len(c);
                end
            end
            apply_cfg();
            d0 = done_ch.size();
            pulse(sub, $urandom_range(1, 3), ts);
            wait_idle();
            check("rnd_ndone", 32'(done_ch.size() - d0), 32'(exp_order.size()));
            foreach (exp_order[k]) check("rnd_order", 32'(qat(done_ch, d0 + k)), 32'(exp_order[k]));
            check("rnd_lat", 32'(qat(done_cyc, d0) - ts), 32'(exp_lat(L0)));
        end
        check_all("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
